// File: rtl/pueo_trig_pkg.sv
// Shared types for the level-two trigger collector: event record layout and
// serializer state encoding.
package pueo_trig_pkg;

  localparam int unsigned TRIG_RECORD_BEATS = 5;

  // "time" is reserved in SystemVerilog, hence tstamp.
  typedef struct packed {
    logic [31:0]      evnum;
    logic [31:0]      tstamp;
    logic [3:0][63:0] meta;
  } trig_record_t;

  typedef enum logic [2:0] {
    SER_IDLE,
    SER_HDR,
    SER_M0,
    SER_M1,
    SER_M2,
    SER_M3
  } ser_state_t;

endpackage

// File: rtl/pueo_trig_fifo.sv
// Synchronous first-word-fall-through FIFO of trigger records with
// full/empty flags and an occupancy count.
module pueo_trig_fifo
  import pueo_trig_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  trig_record_t        wr_data,
  input  logic                pop,
  output trig_record_t        rd_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  trig_record_t          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = count[DEPTH_LOG2];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pueo_trig_collector.sv
// Captures accepted level-two triggers into a record buffer and drains them as a
// 5-beat AXI4-Stream; drives holdoff/dead back. Macro PUEO_TRIGCOLL_DROPCNT_EN enables the drop counter.
module pueo_trig_collector
  import pueo_trig_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned HOLDOFF_BITS    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    ce_i,
  input  logic                    run_i,
  input  logic                    trig_i,
  input  logic [63:0]             tio0_meta_i,
  input  logic [63:0]             tio1_meta_i,
  input  logic [63:0]             tio2_meta_i,
  input  logic [63:0]             tio3_meta_i,
  input  logic [31:0]             time_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_len_i,
  output logic                    holdoff_o,
  output logic                    dead_o,
  output logic [15:0]             drop_count_o,
  output logic [63:0]             evt_tdata_o,
  output logic                    evt_tvalid_o,
  input  logic                    evt_tready_i,
  output logic                    evt_tlast_o
);

  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;

  trig_record_t            in_rec;
  logic                    in_valid;
  trig_record_t            head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic                    full;
  logic                    accept;
  logic                    pop;
  logic [31:0]             evnum;
  logic [HOLDOFF_BITS-1:0] holdoff_cnt;
  logic [HOLDOFF_BITS-1:0] holdoff_cnt_next;
  ser_state_t              state;
  logic [2:0]              beat;
  logic [1:0]              meta_idx;

  // The record in the input register is not yet counted by the FIFO, so it
  // must be reserved here or a trigger in the following cycle could overflow.
  assign full   = fifo_full || (in_valid && fifo_count == CW'(DEPTH - 1));
  assign accept = trig_i && run_i && !full;
  assign pop    = (state == SER_M3) && evt_tready_i;

  always_ff @(posedge clk_i) begin
    if (accept) in_rec <= '{evnum: evnum, tstamp: time_i,
                            meta: {tio3_meta_i, tio2_meta_i, tio1_meta_i, tio0_meta_i}};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      in_valid <= 1'b0;
      evnum    <= '0;
    end else begin
      in_valid <= accept;
      if (!run_i)      evnum <= '0;
      else if (accept) evnum <= evnum + 32'd1;
    end
  end

  pueo_trig_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .push   (in_valid),
    .wr_data(in_rec),
    .pop    (pop),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    holdoff_cnt_next = holdoff_cnt;
    if (accept)                       holdoff_cnt_next = holdoff_len_i;
    else if (ce_i && holdoff_cnt != '0) holdoff_cnt_next = holdoff_cnt - HOLDOFF_BITS'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      holdoff_cnt <= '0;
      holdoff_o   <= 1'b0;
      dead_o      <= 1'b0;
    end else begin
      holdoff_cnt <= holdoff_cnt_next;
      holdoff_o   <= (holdoff_cnt_next != '0);
      dead_o      <= (fifo_count >= CW'(DEPTH - 2));
    end
  end

  // A record being pushed this cycle is at the FIFO head next cycle, so it
  // counts as waiting both for leaving IDLE and for the no-bubble M3 -> HDR.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= SER_IDLE;
    end else begin
      case (state)
        SER_IDLE: if (!fifo_empty || in_valid) state <= SER_HDR;
        SER_HDR:  if (evt_tready_i) state <= SER_M0;
        SER_M0:   if (evt_tready_i) state <= SER_M1;
        SER_M1:   if (evt_tready_i) state <= SER_M2;
        SER_M2:   if (evt_tready_i) state <= SER_M3;
        SER_M3:   if (evt_tready_i)
                    state <= (fifo_count > CW'(1) || in_valid) ? SER_HDR : SER_IDLE;
        default:  state <= SER_IDLE;
      endcase
    end
  end

  assign beat         = 3'(state) - 3'(SER_HDR);
  assign meta_idx     = 2'(beat - 3'd1);
  assign evt_tvalid_o = (state != SER_IDLE);
  assign evt_tlast_o  = (state != SER_IDLE) && (beat == 3'(TRIG_RECORD_BEATS - 1));

  always_comb begin
    evt_tdata_o = '0;
    if (state == SER_HDR)       evt_tdata_o = {head.evnum, head.tstamp};
    else if (state != SER_IDLE) evt_tdata_o = head.meta[meta_idx];
  end

`ifdef PUEO_TRIGCOLL_DROPCNT_EN
  logic [15:0] drop_count;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                                  drop_count <= '0;
    else if (trig_i && run_i && full && drop_count != '1) drop_count <= drop_count + 16'd1;
  end

  assign drop_count_o = drop_count;
`else
  assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_pueo_trig_collector.sv
// Directed self-checking bench for pueo_trig_collector.
module tb_pueo_trig_collector;

`ifdef PUEO_TRIGCOLL_DROPCNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd4;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        run;
  logic        trig;
  logic [63:0] m0, m1, m2, m3;
  logic [31:0] tval;
  logic [15:0] holdoff_len;
  logic        holdoff;
  logic        dead;
  logic [15:0] drop_count;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pueo_trig_collector #(
    .FIFO_DEPTH_LOG2(4),
    .HOLDOFF_BITS   (16)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .ce_i         (ce),
    .run_i        (run),
    .trig_i       (trig),
    .tio0_meta_i  (m0),
    .tio1_meta_i  (m1),
    .tio2_meta_i  (m2),
    .tio3_meta_i  (m3),
    .time_i       (tval),
    .holdoff_len_i(holdoff_len),
    .holdoff_o    (holdoff),
    .dead_o       (dead),
    .drop_count_o (drop_count),
    .evt_tdata_o  (tdata),
    .evt_tvalid_o (tvalid),
    .evt_tready_i (tready),
    .evt_tlast_o  (tlast)
  );

  function automatic logic [63:0] meta_val(input int unsigned k, input int unsigned j);
    return {24'hABCDEF, 8'(j), 32'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trig  = 1'b0;
    tready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fire(input logic [31:0] t, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [63:0] d);
    tval = t; m0 = a; m1 = b; m2 = c; m3 = d;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic get_beat(output logic [63:0] d, output logic l, output bit ok);
    ok = 1'b0;
    d  = '0;
    l  = 1'b0;
    tready = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (tvalid) begin
        d  = tdata;
        l  = tlast;
        ok = 1'b1;
      end
      tick();
    end
    tready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    total++; if (holdoff !== 1'b0) begin bad++; $display("FAIL reset_holdoff got=%b exp=0", holdoff); end
    total++; if (dead !== 1'b0) begin bad++; $display("FAIL reset_dead got=%b exp=0", dead); end
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    total++; if (tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", tlast); end
    total++; if (tdata !== 64'd0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drops got=%0d exp=0", drop_count); end
  endtask

  task automatic test_single();
    logic [63:0] exp_d [5];
    logic [63:0] d;
    logic        l;
    bit          ok;
    int          hcount;
    exp_d = '{64'h0000_0000_0000_0100, 64'hA0, 64'hA1, 64'hA2, 64'hA3};
    do_reset();
    run = 1'b1;
    holdoff_len = 16'd8;
    tick();
    total++; if (holdoff !== 1'b0) begin bad++; $display("FAIL single_holdoff_pre got=%b exp=0", holdoff); end
    fire(32'h100, 64'hA0, 64'hA1, 64'hA2, 64'hA3);
    hcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL single_tvalid_t1 got=%b exp=0", tvalid); end
        total++; if (holdoff !== 1'b1) begin bad++; $display("FAIL single_holdoff_t1 got=%b exp=1", holdoff); end
      end
      if (i == 1) begin
        total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL single_tvalid_t2 got=%b exp=1", tvalid); end
      end
      hcount += int'(holdoff);
      tick();
    end
    total++; if (hcount != 8) begin bad++; $display("FAIL single_holdoff_len got=%0d exp=8", hcount); end
    for (int b = 0; b < 5; b++) begin
      get_beat(d, l, ok);
      total++;
      if (!ok || d !== exp_d[b] || l !== (b == 4)) begin
        bad++;
        $display("FAIL single_beat%0d ok=%0d got=%h/%b exp=%h/%b", b, ok, d, l, exp_d[b], (b == 4));
      end
    end
    tick();
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL single_idle_after got=%b exp=0", tvalid); end
  endtask

  task automatic test_overflow();
    int          beats;
    logic [63:0] exp_d;
    do_reset();
    run = 1'b1;
    holdoff_len = 16'd0;
    tick();
    for (int i = 0; i < 20; i++) begin
      fire(32'h1000 + 32'(i), meta_val(i, 0), meta_val(i, 1), meta_val(i, 2), meta_val(i, 3));
      tick();
      tick();
      if (i == 12) begin
        total++; if (dead !== 1'b0) begin bad++; $display("FAIL ovf_dead_at13 got=%b exp=0", dead); end
      end
      if (i == 13) begin
        total++; if (dead !== 1'b1) begin bad++; $display("FAIL ovf_dead_at14 got=%b exp=1", dead); end
      end
    end
    total++; if (drop_count !== EXP_DROPS) begin bad++; $display("FAIL ovf_drops got=%0d exp=%0d", drop_count, EXP_DROPS); end
    // Continuous drain: no bubbles, 16 records in 80 cycles, evnums 0..15.
    tready = 1'b1;
    beats = 0;
    for (int c = 0; c < 80; c++) begin
      total++;
      if (tvalid !== 1'b1) begin
        bad++;
        $display("FAIL ovf_bubble cycle=%0d got=%b exp=1", c, tvalid);
      end else begin
        exp_d = (beats % 5 == 0) ? {32'(beats / 5), 32'h1000 + 32'(beats / 5)}
                                 : meta_val(beats / 5, (beats % 5) - 1);
        total++;
        if (tdata !== exp_d || tlast !== (beats % 5 == 4)) begin
          bad++;
          $display("FAIL ovf_beat%0d got=%h/%b exp=%h/%b", beats, tdata, tlast, exp_d, (beats % 5 == 4));
        end
        beats++;
      end
      tick();
    end
    tready = 1'b0;
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL ovf_extra_record got=%b exp=0", tvalid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d [15];
    logic [63:0] held_d;
    logic        held_l;
    bit          stalled;
    int          nbeats;
    for (int k = 0; k < 3; k++) begin
      exp_d[k*5] = {32'(k), 32'h2000 + 32'(k)};
      for (int j = 0; j < 4; j++) exp_d[k*5+j+1] = meta_val(32'h20 + k, j);
    end
    do_reset();
    run = 1'b1;
    holdoff_len = 16'd0;
    tick();
    for (int k = 0; k < 3; k++)
      fire(32'h2000 + 32'(k), meta_val(32'h20 + k, 0), meta_val(32'h20 + k, 1),
           meta_val(32'h20 + k, 2), meta_val(32'h20 + k, 3));
    nbeats  = 0;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    for (int c = 0; c < 400 && nbeats < 15; c++) begin
      tready = 1'($urandom_range(0, 1));
      if (stalled) begin
        total++;
        if (tvalid !== 1'b1 || tdata !== held_d || tlast !== held_l) begin
          bad++;
          $display("FAIL b2b_stall_hold got=%b/%h/%b exp=1/%h/%b", tvalid, tdata, tlast, held_d, held_l);
        end
      end
      if (tvalid) begin
        if (tready) begin
          total++;
          if (tdata !== exp_d[nbeats] || tlast !== (nbeats % 5 == 4)) begin
            bad++;
            $display("FAIL b2b_beat%0d got=%h/%b exp=%h/%b", nbeats, tdata, tlast, exp_d[nbeats], (nbeats % 5 == 4));
          end
          nbeats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = tdata;
          held_l  = tlast;
        end
      end
      tick();
    end
    tready = 1'b0;
    total++; if (nbeats != 15) begin bad++; $display("FAIL b2b_beat_count got=%0d exp=15", nbeats); end
    tick();
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b exp=0", tvalid); end
  endtask

  task automatic test_run_low();
    logic [63:0] d;
    logic        l;
    bit          ok;
    int          seen;
    do_reset();
    run = 1'b1;
    holdoff_len = 16'd0;
    tick();
    fire(32'h300, 64'h1, 64'h2, 64'h3, 64'h4);
    get_beat(d, l, ok);
    total++; if (!ok || d !== 64'h0000_0000_0000_0300) begin bad++; $display("FAIL runlow_first_hdr got=%h exp=0000000000000300", d); end
    for (int b = 0; b < 4; b++) get_beat(d, l, ok);
    total++; if (!ok || l !== 1'b1) begin bad++; $display("FAIL runlow_first_last got=%b exp=1", l); end
    run = 1'b0;
    tick();
    fire(32'h301, 64'h5, 64'h6, 64'h7, 64'h8);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      seen += int'(tvalid);
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL runlow_no_record got=%0d exp=0", seen); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL runlow_no_drop got=%0d exp=0", drop_count); end
    run = 1'b1;
    tick();
    fire(32'h302, 64'h9, 64'hA, 64'hB, 64'hC);
    get_beat(d, l, ok);
    total++; if (!ok || d !== 64'h0000_0000_0000_0302) begin bad++; $display("FAIL runlow_evnum_zero got=%h exp=0000000000000302", d); end
    for (int b = 0; b < 4; b++) get_beat(d, l, ok);
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    logic        l;
    bit          ok;
    int          seen;
    do_reset();
    run = 1'b1;
    holdoff_len = 16'd50;
    tick();
    fire(32'h400, 64'h11, 64'h22, 64'h33, 64'h44);
    get_beat(d, l, ok);
    get_beat(d, l, ok);
    total++; if (tvalid !== 1'b1 || tdata !== 64'h22) begin bad++; $display("FAIL mid_at_m1 got=%b/%h exp=1/22", tvalid, tdata); end
    rst_n  = 1'b0;
    tready = 1'b1;
    tick();
    total++; if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 64'd0) begin
      bad++; $display("FAIL mid_reset_outputs got=%b/%b/%h exp=0/0/0", tvalid, tlast, tdata);
    end
    total++; if (holdoff !== 1'b0) begin bad++; $display("FAIL mid_reset_holdoff got=%b exp=0", holdoff); end
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      seen += int'(tvalid);
      tick();
    end
    tready = 1'b0;
    total++; if (seen != 0) begin bad++; $display("FAIL mid_no_resend got=%0d exp=0", seen); end
    holdoff_len = 16'd0;
    fire(32'h401, 64'h55, 64'h66, 64'h77, 64'h88);
    get_beat(d, l, ok);
    total++; if (!ok || d !== 64'h0000_0000_0000_0401) begin bad++; $display("FAIL mid_evnum_zero got=%h exp=0000000000000401", d); end
    for (int b = 0; b < 4; b++) get_beat(d, l, ok);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; run = 1'b0; trig = 1'b0; tready = 1'b0;
    m0 = '0; m1 = '0; m2 = '0; m3 = '0; tval = '0; holdoff_len = '0;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_run_low();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
